// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: shared immediate-format enum, NOP word and immediate range limits
package instr_encoder_pkg;
  typedef enum logic [1:0] {
    FMT_I = 2'b00,
    FMT_S = 2'b01,
    FMT_B = 2'b10,
    FMT_U = 2'b11
  } imm_fmt_e;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int IMM_IS_MIN = -2048;
  localparam int IMM_IS_MAX = 2047;
  localparam int IMM_B_MIN  = -4096;
  localparam int IMM_B_MAX  = 4094;
endpackage

// File: rtl/instr_pack.sv
// instr_pack: packs fields into an RV32I I/S/B/U word and substitutes a NOP when the immediate is out of range
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [1:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        err_o
);
  imm_fmt_e           fmt;
  logic signed [31:0] s_imm;
  logic [31:0]        raw;
  logic               ok;
  assign fmt   = imm_fmt_e'(fmt_i);
  assign s_imm = $signed(imm_i);
  always_comb begin
    case (fmt)
      FMT_I:   raw = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S:   raw = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_B:   raw = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], opcode_i};
      default: raw = {imm_i[31:12], rd_i, opcode_i};
    endcase
  end
  assign ok = (fmt == FMT_U) ? (imm_i[11:0] == 12'd0) :
              (fmt == FMT_B) ? (s_imm >= IMM_B_MIN && s_imm <= IMM_B_MAX && !imm_i[0]) :
                               (s_imm >= IMM_IS_MIN && s_imm <= IMM_IS_MAX);
  assign instr_o = ok ? raw : NOP_INSTR;
  assign err_o   = !ok;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: registered valid/ready stage that emits packed instructions tagged with sequential addresses
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_fmt,
  input  logic [6:0]               in_opcode,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [2:0]               in_funct3,
  input  logic [DATA_WIDTH-1:0]    in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDR_WIDTH-1:0]    out_addr,
  output logic                     out_err,
  output logic                     err_sticky,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);
  logic                     valid_q, valid_d, oerr_q, oerr_d, sticky_q, sticky_d;
  logic [DATA_WIDTH-1:0]    instr_q, instr_d, pack_instr;
  logic [ADDR_WIDTH-1:0]    oaddr_q, oaddr_d, addr_q, addr_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     pack_err, accept;
  instr_pack u_pack (
    .fmt_i   (in_fmt),
    .opcode_i(in_opcode),
    .rd_i    (in_rd),
    .rs1_i   (in_rs1),
    .rs2_i   (in_rs2),
    .funct3_i(in_funct3),
    .imm_i   (in_imm),
    .instr_o (pack_instr),
    .err_o   (pack_err)
  );
  assign in_ready = !clear && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  always_comb begin
    valid_d  = valid_q;
    instr_d  = instr_q;
    oaddr_d  = oaddr_q;
    oerr_d   = oerr_q;
    addr_d   = addr_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (clear) begin
      valid_d  = 1'b0;
      addr_d   = BASE_ADDR;
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (accept) begin
      valid_d  = 1'b1;
      instr_d  = pack_instr;
      oaddr_d  = addr_q;
      oerr_d   = pack_err;
      addr_d   = addr_q + ADDR_WIDTH'(4);
      sticky_d = sticky_q || pack_err;
      cnt_d    = (pack_err && cnt_q != '1) ? cnt_q + ERR_CNT_WIDTH'(1) : cnt_q;
    end else if (out_ready) begin
      valid_d  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      instr_q  <= '0;
      oaddr_q  <= '0;
      oerr_q   <= 1'b0;
      addr_q   <= BASE_ADDR;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      oaddr_q  <= oaddr_d;
      oerr_q   <= oerr_d;
      addr_q   <= addr_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end
  assign out_valid  = valid_q;
  assign out_instr  = instr_q;
  assign out_addr   = oaddr_q;
  assign out_err    = oerr_q;
  assign err_sticky = sticky_q;
  assign err_count  = cnt_q;
endmodule
